// File: rtl/sr04_ranger.sv
// HC-SR04 ranging engine: trigger, echo timing with timeouts, saturating cm count.
// Optional SR04_AVG_EN: o_dist reports the mean of the last four good samples.
`timescale 1ns/1ps
module sr04_ranger #(
    parameter int unsigned DIST_W      = 9,
    parameter int unsigned TRIG_US     = 10,
    parameter int unsigned US_PER_CM   = 58,
    parameter int unsigned TIMEOUT_US  = 30000,
    parameter int unsigned MAX_ECHO_US = 25000,
    parameter int unsigned HOLDOFF_US  = 60000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tick,
    input  logic              i_start,
    input  logic              i_mode_cont,
    input  logic              i_echo,
    output logic              o_trig,
    output logic [DIST_W-1:0] o_dist,
    output logic              o_valid,
    output logic              o_err,
    output logic              o_busy
);
    localparam int unsigned M1      = (TIMEOUT_US > MAX_ECHO_US) ? TIMEOUT_US : MAX_ECHO_US;
    localparam int unsigned M2      = (HOLDOFF_US > TRIG_US) ? HOLDOFF_US : TRIG_US;
    localparam int unsigned CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned SUB_W   = $clog2(US_PER_CM + 1);

    typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [DIST_W-1:0] cm_q, cm_d, cm_t;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic [2:0]        echo_q;
    logic              echo_rise, echo_fall, good, err_hit;

    assign echo_rise = echo_q[1] & ~echo_q[2];
    assign echo_fall = ~echo_q[1] & echo_q[2];
    assign cnt_inc   = cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sub_q   <= '0;
            cm_q    <= '0;
            dist_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            echo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            cm_q    <= cm_d;
            dist_q  <= dist_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            echo_q  <= {echo_q[1:0], i_echo};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        cm_d    = cm_q;
        cm_t    = cm_q;
        err_d   = err_q;
        valid_d = 1'b0;
        good    = 1'b0;
        err_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (i_start || i_mode_cont) state_d = S_TRIG;
            end
            S_TRIG: begin
                if (i_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TRIG_US)) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT: begin
                if (echo_rise) begin
                    state_d = S_MEAS;
                    cnt_d   = '0;
                    sub_d   = '0;
                    cm_d    = '0;
                end else if (i_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT_US)) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                        valid_d = 1'b1;
                    end
                end
            end
            S_MEAS: begin
                // The tick of this clk is folded into cm_t before any edge closes the measurement.
                if (i_tick) begin
                    cnt_d = cnt_inc;
                    if (sub_q == SUB_W'(US_PER_CM - 1)) begin
                        sub_d = '0;
                        if (cm_q != '1) cm_t = cm_q + 1'b1;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                    if (cnt_inc == CNT_W'(MAX_ECHO_US)) err_hit = 1'b1;
                end
                cm_d = cm_t;
                if (err_hit) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                end else if (echo_fall) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    good    = 1'b1;
                end
            end
            S_HOLD: begin
                if (i_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(HOLDOFF_US)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef SR04_AVG_EN
    logic [DIST_W-1:0] h0_q, h1_q, h2_q;
    logic              primed_q;
    logic [DIST_W+1:0] avg_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h0_q     <= '0;
            h1_q     <= '0;
            h2_q     <= '0;
            primed_q <= 1'b0;
        end else if (good) begin
            primed_q <= 1'b1;
            h0_q     <= cm_t;
            h1_q     <= primed_q ? h0_q : cm_t;
            h2_q     <= primed_q ? h1_q : cm_t;
        end
    end

    always_comb begin
        dist_d = dist_q;
        // Before the first good sample every slot is treated as holding the new value.
        if (primed_q)
            avg_sum = {2'b00, cm_t} + {2'b00, h0_q} + {2'b00, h1_q} + {2'b00, h2_q};
        else
            avg_sum = {cm_t, 2'b00};
        if (good) dist_d = DIST_W'(avg_sum >> 2);
    end
`else
    always_comb begin
        dist_d = dist_q;
        if (good) dist_d = cm_t;
    end
`endif

    assign o_trig  = (state_q == S_TRIG);
    assign o_busy  = (state_q != S_IDLE);
    assign o_valid = valid_q;
    assign o_err   = err_q;
    assign o_dist  = dist_q;
endmodule

// File: tb/tb_sr04_ranger.sv
// Directed bench for sr04_ranger with shortened timeouts; a DIST_W=4 copy checks saturation.
`timescale 1ns/1ps
module tb_sr04_ranger;
    localparam int TICK_DIV = 6;
    localparam int TR = 10;
    localparam int TO = 300;
    localparam int MX = 2400;
    localparam int HO = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_tick = 1'b0;
    logic       i_start = 1'b0;
    logic       i_mode_cont = 1'b0;
    logic       i_echo = 1'b0;
    logic       o_trig, o_valid, o_err, o_busy;
    logic [8:0] o_dist;
    logic       t2_trig, t2_valid, t2_err, t2_busy;
    logic [3:0] t2_dist;

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt = 0;
    int trig_rises = 0;
    logic trig_prev = 1'b0;

    sr04_ranger #(.DIST_W(9), .TRIG_US(TR), .US_PER_CM(58), .TIMEOUT_US(TO),
                  .MAX_ECHO_US(MX), .HOLDOFF_US(HO)) dut (
        .clk(clk), .rst(rst), .i_tick(i_tick), .i_start(i_start),
        .i_mode_cont(i_mode_cont), .i_echo(i_echo), .o_trig(o_trig),
        .o_dist(o_dist), .o_valid(o_valid), .o_err(o_err), .o_busy(o_busy));

    sr04_ranger #(.DIST_W(4), .TRIG_US(TR), .US_PER_CM(58), .TIMEOUT_US(TO),
                  .MAX_ECHO_US(MX), .HOLDOFF_US(HO)) dut_sat (
        .clk(clk), .rst(rst), .i_tick(i_tick), .i_start(i_start),
        .i_mode_cont(i_mode_cont), .i_echo(i_echo), .o_trig(t2_trig),
        .o_dist(t2_dist), .o_valid(t2_valid), .o_err(t2_err), .o_busy(t2_busy));

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            i_tick = 1'b1;
            @(negedge clk);
            i_tick = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (o_valid) vcnt++;
        if (o_trig && !trig_prev) trig_rises++;
        trig_prev = o_trig;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns on the falling edge right after a tick has been consumed.
    task automatic align();
        for (int k = 0; k < 4 * TICK_DIV; k++) begin
            step();
            if (i_tick) break;
        end
        @(negedge clk);
    endtask

    function automatic bit cond_met(input int what);
        case (what)
            0:       return o_trig;
            1:       return !o_trig;
            2:       return o_valid;
            default: return !o_busy;
        endcase
    endfunction

    // Counts ticks after the call up to and including the cycle the event is seen.
    task automatic wait_for(input int what, input int limit, output int ticks);
        ticks = 0;
        for (int c = 0; c < limit * TICK_DIV + 64; c++) begin
            step();
            if (i_tick) ticks++;
            if (cond_met(what)) return;
        end
        n_tests++; n_fail++;
        $display("FAIL wait_event_%0d got timeout exp event within %0d ticks", what, limit);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        i_start = 1'b0;
        i_mode_cont = 1'b0;
        i_echo = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic echo_ticks(input int n, input int poke);
        align();
        i_echo = 1'b1;
        for (int t = 1; t <= n; t++) begin
            align();
            if (t == poke) begin
                i_start = 1'b1;
                @(negedge clk);
                i_start = 1'b0;
            end
        end
        i_echo = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        if (o_trig !== 1'b0)  begin n_fail++; $display("FAIL reset_trig got %b exp 0", o_trig); end n_tests++;
        if (o_dist !== 9'd0)  begin n_fail++; $display("FAIL reset_dist got %0d exp 0", o_dist); end n_tests++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", o_valid); end n_tests++;
        if (o_err !== 1'b0)   begin n_fail++; $display("FAIL reset_err got %b exp 0", o_err); end n_tests++;
        if (o_busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b exp 0", o_busy); end n_tests++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_trig();
        int t;
        pulse_start();
        wait_for(0, 20, t);
        rst = 1'b1;
        #1;
        if (o_trig !== 1'b0)  begin n_fail++; $display("FAIL midtrig_trig got %b exp 0", o_trig); end n_tests++;
        if (o_busy !== 1'b0)  begin n_fail++; $display("FAIL midtrig_busy got %b exp 0", o_busy); end n_tests++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midtrig_valid got %b exp 0", o_valid); end n_tests++;
        if (o_dist !== 9'd0)  begin n_fail++; $display("FAIL midtrig_dist got %0d exp 0", o_dist); end n_tests++;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) step();
        if (o_busy !== 1'b0)  begin n_fail++; $display("FAIL midtrig_idle got %b exp 0", o_busy); end n_tests++;
    endtask

    task automatic test_single();
        int t, v0;
        do_reset();
        v0 = vcnt;
        pulse_start();
        wait_for(0, 20, t);
        wait_for(1, TR + 5, t);
        if (t != TR) begin n_fail++; $display("FAIL trig_width got %0d exp %0d", t, TR); end n_tests++;
        echo_ticks(580, 0);
        wait_for(2, 20, t);
        if (o_dist !== 9'd10) begin n_fail++; $display("FAIL single_dist got %0d exp 10", o_dist); end n_tests++;
        if (o_err !== 1'b0)   begin n_fail++; $display("FAIL single_err got %b exp 0", o_err); end n_tests++;
        if (o_busy !== 1'b1)  begin n_fail++; $display("FAIL single_busy got %b exp 1", o_busy); end n_tests++;
        wait_for(3, HO + 5, t);
        if (t != HO) begin n_fail++; $display("FAIL single_holdoff got %0d exp %0d", t, HO); end n_tests++;
        step();
        if (vcnt - v0 != 1) begin n_fail++; $display("FAIL single_valid_count got %0d exp 1", vcnt - v0); end n_tests++;
    endtask

    task automatic test_no_echo();
        int t;
        pulse_start();
        wait_for(0, 20, t);
        wait_for(1, TR + 5, t);
        wait_for(2, TO + 5, t);
        if (t != TO) begin n_fail++; $display("FAIL noecho_ticks got %0d exp %0d", t, TO); end n_tests++;
        if (o_err !== 1'b1)   begin n_fail++; $display("FAIL noecho_err got %b exp 1", o_err); end n_tests++;
        if (o_dist !== 9'd10) begin n_fail++; $display("FAIL noecho_dist got %0d exp 10", o_dist); end n_tests++;
        wait_for(3, HO + 5, t);
    endtask

    task automatic test_over_range();
        int t, v0;
        v0 = vcnt;
        pulse_start();
        wait_for(0, 20, t);
        wait_for(1, TR + 5, t);
        align();
        i_echo = 1'b1;
        wait_for(2, MX + 20, t);
        if (t != MX) begin n_fail++; $display("FAIL over_ticks got %0d exp %0d", t, MX); end n_tests++;
        if (o_err !== 1'b1)   begin n_fail++; $display("FAIL over_err got %b exp 1", o_err); end n_tests++;
        if (o_dist !== 9'd10) begin n_fail++; $display("FAIL over_dist got %0d exp 10", o_dist); end n_tests++;
        for (int k = 0; k < 60; k++) align();
        i_echo = 1'b0;
        wait_for(3, HO + 5, t);
        step();
        if (vcnt - v0 != 1) begin n_fail++; $display("FAIL over_valid_count got %0d exp 1", vcnt - v0); end n_tests++;
        if (o_err !== 1'b1) begin n_fail++; $display("FAIL over_err_hold got %b exp 1", o_err); end n_tests++;
    endtask

    task automatic test_saturation();
        int t;
        do_reset();
        pulse_start();
        wait_for(0, 20, t);
        wait_for(1, TR + 5, t);
        echo_ticks(1000, 0);
        wait_for(2, 20, t);
        if (t2_dist !== 4'd15) begin n_fail++; $display("FAIL sat_dist4 got %0d exp 15", t2_dist); end n_tests++;
        if (o_dist !== 9'd17)  begin n_fail++; $display("FAIL sat_dist9 got %0d exp 17", o_dist); end n_tests++;
        if (t2_err !== 1'b0)   begin n_fail++; $display("FAIL sat_err got %b exp 0", t2_err); end n_tests++;
        wait_for(3, HO + 5, t);
    endtask

    task automatic test_continuous();
        int t, r0;
        int exp2;
`ifdef SR04_AVG_EN
        exp2 = 12;
`else
        exp2 = 20;
`endif
        do_reset();
        @(negedge clk);
        i_mode_cont = 1'b1;
        wait_for(0, 20, t);
        wait_for(1, TR + 5, t);
        echo_ticks(580, 0);
        wait_for(2, 20, t);
        if (o_dist !== 9'd10) begin n_fail++; $display("FAIL cont_dist1 got %0d exp 10", o_dist); end n_tests++;
        wait_for(0, HO + 20, t);
        if (t != HO) begin n_fail++; $display("FAIL cont_retrig got %0d exp %0d", t, HO); end n_tests++;
        r0 = trig_rises;
        wait_for(1, TR + 5, t);
        @(negedge clk);
        i_mode_cont = 1'b0;
        echo_ticks(1160, 0);
        wait_for(2, 20, t);
        if (o_dist !== 9'(exp2)) begin n_fail++; $display("FAIL cont_dist2 got %0d exp %0d", o_dist, exp2); end n_tests++;
        wait_for(3, HO + 5, t);
        repeat (30 * TICK_DIV) step();
        if (o_busy !== 1'b0)  begin n_fail++; $display("FAIL cont_stop_busy got %b exp 0", o_busy); end n_tests++;
        if (trig_rises != r0) begin n_fail++; $display("FAIL cont_stop_trig got %0d exp %0d", trig_rises, r0); end n_tests++;
    endtask

    task automatic test_start_ignored();
        int t, v0, r0;
        v0 = vcnt;
        r0 = trig_rises;
        pulse_start();
        wait_for(0, 20, t);
        wait_for(1, TR + 5, t);
        echo_ticks(580, 100);
        wait_for(2, 20, t);
        wait_for(3, HO + 5, t);
        repeat (10 * TICK_DIV) step();
        if (trig_rises - r0 != 1) begin n_fail++; $display("FAIL ignore_trig got %0d exp 1", trig_rises - r0); end n_tests++;
        if (vcnt - v0 != 1)       begin n_fail++; $display("FAIL ignore_valid got %0d exp 1", vcnt - v0); end n_tests++;
    endtask

`ifdef SR04_AVG_EN
    task automatic test_avg();
        int t;
        int exp_avg [4] = '{10, 12, 17, 25};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pulse_start();
            wait_for(0, 20, t);
            wait_for(1, TR + 5, t);
            echo_ticks(580 * (i + 1), 0);
            wait_for(2, 20, t);
            if (o_dist !== 9'(exp_avg[i])) begin n_fail++; $display("FAIL avg_%0d got %0d exp %0d", i, o_dist, exp_avg[i]); end n_tests++;
            wait_for(3, HO + 5, t);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_trig();
        test_single();
        test_no_echo();
        test_over_range();
        test_saturation();
        test_continuous();
        test_start_ignored();
`ifdef SR04_AVG_EN
        test_avg();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
